// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART types plus default FIFO depth and RTS watermarks.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W          = 8;
    localparam int UART_FIFO_DEPTH_LOG2 = 4;
    localparam int UART_RTS_HIGH        = 12;
    localparam int UART_RTS_LOW         = 4;

    typedef logic [UART_DATA_W-1:0] uart_byte_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Receive-side byte stream, consumer handshake and status bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
);

    uart_byte_t            in_data;
    logic                  in_valid;
    uart_byte_t            out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  rts;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic                  clear_overflow;

    modport slave (
        input  in_data, in_valid, out_ready, clear_overflow,
        output out_data, out_valid, rts, count, overflow
    );

    modport master (
        output in_data, in_valid, out_ready, clear_overflow,
        input  out_data, out_valid, rts, count, overflow
    );

endinterface : uart_rx_fifo_if
`default_nettype wire

// File: rtl/uart_fifo_ram.sv
`default_nettype none
// ============================================================================
// Module      : uart_fifo_ram
// Description : Byte array with one synchronous write port and async read.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_ram
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2
) (
    input  wire logic                  clk,
    input  wire logic                  wr_en,
    input  wire logic [DEPTH_LOG2-1:0] wr_addr,
    input  wire uart_byte_t            wr_data,
    input  wire logic [DEPTH_LOG2-1:0] rd_addr,
    output      uart_byte_t            rd_data
);

    // Contents are deliberately not reset; the top masks them with out_valid.
    uart_byte_t mem [2**DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule : uart_fifo_ram
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : FWFT receive FIFO with RTS watermark hysteresis and sticky
//               overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = UART_FIFO_DEPTH_LOG2,
    parameter int RTS_HIGH   = UART_RTS_HIGH,
    parameter int RTS_LOW    = UART_RTS_LOW
) (
    input wire logic      clk,
    input wire logic      reset_n,
    uart_rx_fifo_if.slave bus
);

    localparam int PTR_W = DEPTH_LOG2 + 1;
    localparam logic [PTR_W-1:0] c_RTS_HIGH = PTR_W'(RTS_HIGH);
    localparam logic [PTR_W-1:0] c_RTS_LOW  = PTR_W'(RTS_LOW);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic             rts_q, rts_d;
    logic             overflow_q, overflow_d;

    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [PTR_W-1:0] w_next_count;

    always_comb begin
        w_empty = (wr_ptr_q == rd_ptr_q);
        w_full  = (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]) &&
                  (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]);
        w_pop   = !w_empty && bus.out_ready;
        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        w_push  = bus.in_valid && (!w_full || w_pop);
        w_drop  = bus.in_valid && w_full && !w_pop;

        wr_ptr_d     = wr_ptr_q + PTR_W'(w_push);
        rd_ptr_d     = rd_ptr_q + PTR_W'(w_pop);
        w_next_count = wr_ptr_d - rd_ptr_d;

        rts_d = rts_q;
        if (w_next_count >= c_RTS_HIGH) begin
            rts_d = 1'b1;
        end else if (w_next_count <= c_RTS_LOW) begin
            rts_d = 1'b0;
        end

        overflow_d = overflow_q;
        if (w_drop) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rts_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rts_q      <= rts_d;
            overflow_q <= overflow_d;
        end
    end

    uart_fifo_ram #(
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_ram (
        .clk     (clk),
        .wr_en   (w_push),
        .wr_addr (wr_ptr_q[DEPTH_LOG2-1:0]),
        .wr_data (bus.in_data),
        .rd_addr (rd_ptr_q[DEPTH_LOG2-1:0]),
        .rd_data (bus.out_data)
    );

    assign bus.out_valid = !w_empty;
    assign bus.count     = wr_ptr_q - rd_ptr_q;
    assign bus.rts       = rts_q;
    assign bus.overflow  = overflow_q;

endmodule : uart_rx_fifo
`default_nettype wire

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Byte buffer between the UART receiver and the consuming logic. Captures each single-cycle `in_valid` byte pulse into a power-of-two circular FIFO and presents bytes with a first-word-fall-through valid/ready interface. Drives the RTS flow-control line with watermark hysteresis so the remote sender pauses before the buffer overruns. Flags lost bytes with a sticky overflow bit.

## Interface
- `DEPTH_LOG2`, default 4: FIFO depth = 2^DEPTH_LOG2 bytes; legal range 2..10.
- `RTS_HIGH`, default 12: occupancy at or above which RTS is deasserted (stop).
- `RTS_LOW`, default 4: occupancy at or below which RTS is reasserted (go). Required: 0 <= RTS_LOW < RTS_HIGH <= 2^DEPTH_LOG2.

- `clk` in 1: single clock for all logic.
- `reset_n` in 1: asynchronous, active-low reset.
- `in_data` in 8: received byte, sampled only when `in_valid`=1.
- `in_valid` in 1: one-cycle strobe from the receiver; there is no backpressure on this side.
- `out_data` out 8: head-of-FIFO byte; meaningful only when `out_valid`=1.
- `out_valid` out 1: FIFO not empty.
- `out_ready` in 1: consumer accepts the head byte this cycle.
- `rts` out 1: active-low permission to send; 0 = sender may transmit, 1 = stop.
- `count` out DEPTH_LOG2+1: current occupancy, 0..2^DEPTH_LOG2.
- `overflow` out 1: sticky flag; at least one byte was dropped.
- `clear_overflow` in 1: synchronous clear of `overflow`.

## Operation
- Storage: 2^DEPTH_LOG2 x 8 array. Write and read pointers are DEPTH_LOG2+1 bits and wrap naturally. The low bits index the array.
  - empty = pointers equal.
  - full = low bits equal and MSBs differ.
  - `count` = wr_ptr - rd_ptr, modulo 2^(DEPTH_LOG2+1).
- Push: `in_valid`=1 and (not full, or pop in the same cycle) → write `in_data` at wr_ptr, then wr_ptr+1.
- Drop: `in_valid`=1, full, and no pop → byte is discarded, pointers are unchanged, and `overflow` is set to 1.
- Pop: `out_valid`=1 and `out_ready`=1 → rd_ptr+1.
- Simultaneous push and pop:
  - When full: the push is accepted and `count` stays 2^DEPTH_LOG2.
  - When empty: no pop occurs because `out_valid`=0; the push proceeds.
- `out_data` = array[rd_ptr low bits], combinational from the registered state. It is first-word-fall-through.
- `overflow`:
  - Set takes priority over `clear_overflow` in the same cycle.
  - Otherwise `clear_overflow`=1 clears it.
- RTS hysteresis (registered), evaluated on the next-state count:
  - next_count >= RTS_HIGH → `rts`=1.
  - next_count <= RTS_LOW → `rts`=0.
  - Otherwise `rts` holds its value.
- Reset values: pointers 0, `count`=0, `out_valid`=0, `rts`=0, `overflow`=0. The array contents are not reset, so `out_data` is don't-care while `out_valid`=0.

## Timing
- Push at edge k → `out_valid`=1 and `out_data` valid in the cycle after edge k (1-cycle latency).
- Pop at edge k → the next byte is presented in the cycle after edge k. Back-to-back pops give one byte per cycle.
- `count`, `out_valid`, and `rts` all update on the same edge as the push or pop that caused the change. There is no extra lag on `rts`.
- Reset mid-operation: all buffered bytes are discarded immediately when `reset_n` goes low. Operation resumes on the first `clk` edge after `reset_n` rises.
- Input pulses arrive at most once every ~100 cycles at typical baud rates, but the block must accept `in_valid` on every cycle.

## Structure
- Shared package `uart_pkg`:
  - constant `UART_DATA_W` = 8.
  - typedef `uart_byte_t`.
  - the default depth and watermark constants, which are also used by the transmitter side.
- Sub-module `uart_fifo_ram`: write-port array with asynchronous read. The top level holds the pointers, flags, and RTS logic.

## Test plan
- Reset, then push 0x41, 0x42, 0x43 with `out_ready`=0 → `count`=3, `out_data`=0x41. Then raise `out_ready` → bytes emerge in order 0x41, 0x42, 0x43 on consecutive cycles, then `out_valid`=0.
- Push 12 bytes with `out_ready`=0 (defaults) → `rts` goes 1 on the edge of the 12th push. Pop 8 → `rts` stays 1 at count 5 and goes 0 on the pop that reaches count 4.
- Fill to 16, then push 0xEE → byte dropped, `count`=16, `overflow`=1. Pop all 16 → original sequence intact with no 0xEE. Then pulse `clear_overflow` → `overflow`=0.
- Full FIFO, with push 0x55 and pop in the same cycle → `count` stays 16, `overflow` stays 0, and 0x55 is the last byte out.
- Push 40 bytes with interleaved pops, keeping occupancy at or below 3 → data order is preserved across pointer wrap and `rts` stays 0 throughout.
- Assert `reset_n`=0 with 7 bytes buffered and `rts` arbitrary → in the same cycle `count`=0, `out_valid`=0, `rts`=0, `overflow`=0.
